// File: rtl/cg_ptw_pkg.sv
// -----------------------------------------------------------------------------
// cg_ptw_pkg
// Shared definitions for the Sv39 page-table walker: address/PTE geometry,
// PTE bit positions, FSM state encodings and a VPN field extractor.
// -----------------------------------------------------------------------------
package cg_ptw_pkg;

    // Sv39 geometry
    localparam int VADDR_WIDTH   = 39;
    localparam int PADDR_WIDTH   = 56;
    localparam int PPN_WIDTH     = 44;
    localparam int OFFSET_WIDTH  = 12;
    localparam int VPN_WIDTH     = 9;
    localparam int LEVELS        = 3;
    localparam int PTE_WIDTH     = 64;
    localparam int PTE_SIZE_LOG2 = 3;
    localparam int VPN_ALL_WIDTH = LEVELS * VPN_WIDTH;

    localparam logic [1:0] TOP_LEVEL = 2'(LEVELS - 1);

    // PTE bit positions
    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_A       = 6;
    localparam int PTE_D       = 7;
    localparam int PTE_PPN_LSB = 10;

    // Walker FSM states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_REQ   = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_FAULT = 3'd4;

    // Select the VPN field of a level from the packed {vpn2, vpn1, vpn0}.
    function automatic logic [VPN_WIDTH-1:0] vpn_field(
        input logic [VPN_ALL_WIDTH-1:0] vpn,
        input logic [1:0]               level
    );
        case (level)
            2'd0:    return vpn[VPN_WIDTH-1:0];
            2'd1:    return vpn[2*VPN_WIDTH-1:VPN_WIDTH];
            default: return vpn[3*VPN_WIDTH-1:2*VPN_WIDTH];
        endcase
    endfunction

endpackage

// File: rtl/cg_ptw_pte_check.sv
// -----------------------------------------------------------------------------
// cg_ptw_pte_check
// Combinational Sv39 PTE decoder. Classifies a fetched PTE at a given level as
// leaf / pointer / fault and produces the PPN to use next: the next table PPN
// for a pointer, or the final PPN (superpage low bits filled from the VA) for
// a leaf.
//
// Configuration macro: CG_PTW_AD_CHECK_EN -- when defined, a leaf with A=0
// faults (D is not checked, walks are reads).
//
// Ports:
//   pte       in  PTE_WIDTH      fetched page-table entry
//   level     in  2              level the PTE was read at (2 = root)
//   vpn_low   in  2*VPN_WIDTH    {vpn1, vpn0} of the missing VA
//   is_leaf   out 1              PTE has R or X set
//   is_fault  out 1              walk must terminate with a page fault
//   next_ppn  out PPN_WIDTH      next table PPN or translated leaf PPN
// -----------------------------------------------------------------------------
module cg_ptw_pte_check
    import cg_ptw_pkg::*;
(
    input  logic [PTE_WIDTH-1:0]   pte,
    input  logic [1:0]             level,
    input  logic [2*VPN_WIDTH-1:0] vpn_low,
    output logic                   is_leaf,
    output logic                   is_fault,
    output logic [PPN_WIDTH-1:0]   next_ppn
);

    logic [PPN_WIDTH-1:0] pte_ppn;
    logic                 misaligned;
    logic                 ad_fault;

    assign pte_ppn = pte[PTE_PPN_LSB +: PPN_WIDTH];

    // Reserved, RSW, U, G and D bits do not influence a read walk.
    logic unused_pte_bits;
    assign unused_pte_bits = ^{pte[PTE_WIDTH-1:PTE_PPN_LSB+PPN_WIDTH],
                               pte[PTE_PPN_LSB-1:PTE_D+1], pte[PTE_D:4]};

`ifdef CG_PTW_AD_CHECK_EN
    assign ad_fault = ~pte[PTE_A];
`else
    assign ad_fault = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statements can leave a latch behind.
    always_comb begin
        is_leaf    = pte[PTE_R] | pte[PTE_X];
        misaligned = 1'b0;
        next_ppn   = pte_ppn;

        // A superpage leaf must have zeros in the PPN bits that the VA supplies.
        case (level)
            2'd1:    misaligned = |pte_ppn[VPN_WIDTH-1:0];
            2'd2:    misaligned = |pte_ppn[2*VPN_WIDTH-1:0];
            default: misaligned = 1'b0;
        endcase

        if (is_leaf) begin
            case (level)
                2'd1:    next_ppn[VPN_WIDTH-1:0]   = vpn_low[VPN_WIDTH-1:0];
                2'd2:    next_ppn[2*VPN_WIDTH-1:0] = vpn_low;
                default: next_ppn                  = pte_ppn;
            endcase
        end

        is_fault = ~pte[PTE_V]
                 | (~pte[PTE_R] & pte[PTE_W])
                 | (is_leaf & (misaligned | ad_fault))
                 | (~is_leaf & (level == 2'd0));
    end

endmodule

// File: rtl/cg_ptw_sv39.sv
// -----------------------------------------------------------------------------
// cg_ptw_sv39
// Sv39 hardware page-table walker serving TLB misses. Walks up to three levels
// through a single-outstanding memory read port and returns either a one-cycle
// fill pulse with the translated PA or a one-cycle page-fault pulse.
//
// Configuration macro: CG_PTW_AD_CHECK_EN (see cg_ptw_pte_check).
//
// Ports:
//   i_clk, i_rstn       clock, asynchronous active-low reset
//   i_tlb_miss          miss request, accepted only while idle
//   i_tlb_miss_vaddr    missing virtual address
//   o_ptw_valid         fill pulse; o_ptw_paddr = {PPN, 12'b0}
//   o_ptw_fault         page-fault pulse
//   i_satp_ppn          root page-table PPN
//   i_flush             abort the current walk
//   o_mem_req/addr      PTE read request, held until i_mem_ready
//   i_mem_ready         request accepted
//   i_mem_rvalid/rdata  PTE read data
// -----------------------------------------------------------------------------
module cg_ptw_sv39
    import cg_ptw_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_tlb_miss,
    input  logic [VADDR_WIDTH-1:0] i_tlb_miss_vaddr,
    output logic                   o_ptw_valid,
    output logic [PADDR_WIDTH-1:0] o_ptw_paddr,
    output logic                   o_ptw_fault,
    input  logic [PPN_WIDTH-1:0]   i_satp_ppn,
    input  logic                   i_flush,
    output logic                   o_mem_req,
    output logic [PADDR_WIDTH-1:0] o_mem_addr,
    input  logic                   i_mem_ready,
    input  logic                   i_mem_rvalid,
    input  logic [PTE_WIDTH-1:0]   i_mem_rdata
);

    state_t                   state;
    logic [1:0]               level;
    logic [PPN_WIDTH-1:0]     table_ppn;
    logic [VPN_ALL_WIDTH-1:0] vpn;
    logic [PPN_WIDTH-1:0]     result_ppn;
    logic                     abort;

    logic                     chk_leaf;
    logic                     chk_fault;
    logic [PPN_WIDTH-1:0]     chk_ppn;

    // The page offset never takes part in the walk.
    logic unused_offset;
    assign unused_offset = ^i_tlb_miss_vaddr[OFFSET_WIDTH-1:0];

    cg_ptw_pte_check u_pte_check (
        .pte      (i_mem_rdata),
        .level    (level),
        .vpn_low  (vpn[2*VPN_WIDTH-1:0]),
        .is_leaf  (chk_leaf),
        .is_fault (chk_fault),
        .next_ppn (chk_ppn)
    );

    // Address is built from registered state only, so it cannot move while
    // a request waits for i_mem_ready.
    assign o_mem_addr  = {table_ppn, vpn_field(vpn, level), {PTE_SIZE_LOG2{1'b0}}};
    assign o_ptw_paddr = {result_ppn, {OFFSET_WIDTH{1'b0}}};

    // A flush suppresses a request or a response pulse in the same cycle.
    assign o_mem_req   = (state == ST_REQ)   & ~i_flush;
    assign o_ptw_valid = (state == ST_DONE)  & ~i_flush;
    assign o_ptw_fault = (state == ST_FAULT) & ~i_flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= ST_IDLE;
            level      <= TOP_LEVEL;
            table_ppn  <= '0;
            vpn        <= '0;
            result_ppn <= '0;
            abort      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_tlb_miss && !i_flush) begin
                        vpn       <= i_tlb_miss_vaddr[VADDR_WIDTH-1:OFFSET_WIDTH];
                        level     <= TOP_LEVEL;
                        table_ppn <= i_satp_ppn;
                        state     <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (i_flush) begin
                        state <= ST_IDLE;
                    end else if (i_mem_ready) begin
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (i_mem_rvalid) begin
                        abort <= 1'b0;
                        if (abort || i_flush) begin
                            // Flushed walk: the read is drained, its data dropped.
                            state <= ST_IDLE;
                        end else if (chk_fault) begin
                            state <= ST_FAULT;
                        end else if (chk_leaf) begin
                            result_ppn <= chk_ppn;
                            state      <= ST_DONE;
                        end else begin
                            table_ppn <= chk_ppn;
                            level     <= level - 2'd1;
                            state     <= ST_REQ;
                        end
                    end else if (i_flush) begin
                        abort <= 1'b1;
                    end
                end

                ST_DONE:  state <= ST_IDLE;
                ST_FAULT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cg_ptw_sv39.sv
module tb_cg_ptw_sv39;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_tlb_miss = 1'b0;
    logic [38:0] i_tlb_miss_vaddr = '0;
    logic        o_ptw_valid;
    logic [55:0] o_ptw_paddr;
    logic        o_ptw_fault;
    logic [43:0] i_satp_ppn = '0;
    logic        i_flush = 1'b0;
    logic        o_mem_req;
    logic [55:0] o_mem_addr;
    logic        i_mem_ready = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [63:0] i_mem_rdata = '0;

    always #5 i_clk = ~i_clk;

    cg_ptw_sv39 dut (
        .i_clk            (i_clk),
        .i_rstn           (i_rstn),
        .i_tlb_miss       (i_tlb_miss),
        .i_tlb_miss_vaddr (i_tlb_miss_vaddr),
        .o_ptw_valid      (o_ptw_valid),
        .o_ptw_paddr      (o_ptw_paddr),
        .o_ptw_fault      (o_ptw_fault),
        .i_satp_ppn       (i_satp_ppn),
        .i_flush          (i_flush),
        .o_mem_req        (o_mem_req),
        .o_mem_addr       (o_mem_addr),
        .i_mem_ready      (i_mem_ready),
        .i_mem_rvalid     (i_mem_rvalid),
        .i_mem_rdata      (i_mem_rdata)
    );

    localparam logic [7:0] NL   = 8'h01;  // V only: pointer
    localparam logic [7:0] LEAF = 8'hCB;  // V R X A D
    localparam logic [7:0] NOA  = 8'h8B;  // V R X D, A clear

    typedef struct {
        logic        fault;
        logic [55:0] paddr;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    exp_t        exp_cur;
    int          pulse_count = 0;
    int          pulse_cycs[$];
    int          hs_count = 0;
    logic [55:0] hs_addrs[$];
    logic [55:0] hs_addr;
    logic [55:0] rv_addr;
    bit          hs_seen = 0;
    bit          outstanding = 0;
    bit          rv_pending = 0;
    int          rv_wait = 0;
    int          rdy_cnt = 0;
    int          ready_delay = 0;
    int          rvalid_delay = 0;
    logic [63:0] mem [logic [55:0]];

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Observe handshakes and result pulses mid-cycle; inputs change only
    // just after the rising edge, so both sides are stable here.
    initial forever begin
        @(negedge i_clk);
        if (i_rstn) begin
            if (i_mem_rvalid) outstanding = 0;
            if (o_mem_req && i_mem_ready) begin
                checks++;
                if (outstanding) begin
                    failures++;
                    $display("FAIL one_outstanding: request at %h while a read is pending", o_mem_addr);
                end
                hs_count++;
                hs_addrs.push_back(o_mem_addr);
                hs_addr = o_mem_addr;
                hs_seen = 1;
                outstanding = 1;
            end
            if (o_ptw_valid || o_ptw_fault) begin
                pulse_count++;
                pulse_cycs.push_back(cyc);
                checks++;
                if (o_ptw_valid && o_ptw_fault) begin
                    failures++;
                    $display("FAIL exclusive_pulse: valid=1 fault=1 at cycle %0d, required at most one", cyc);
                end else if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: valid=%b fault=%b paddr=%h, required no pulse",
                             o_ptw_valid, o_ptw_fault, o_ptw_paddr);
                end else begin
                    exp_cur = exp_q.pop_front();
                    if (o_ptw_fault !== exp_cur.fault ||
                        (!exp_cur.fault && o_ptw_paddr !== exp_cur.paddr)) begin
                        failures++;
                        $display("FAIL fill_result: got fault=%b paddr=%h, required fault=%b paddr=%h",
                                 o_ptw_fault, o_ptw_paddr, exp_cur.fault, exp_cur.paddr);
                    end
                end
            end
        end
    end

    // Memory port model: programmable ready stall and read latency.
    initial forever begin
        @(posedge i_clk);
        #1;
        i_mem_rvalid = 0;
        if (hs_seen) begin
            hs_seen = 0;
            rv_pending = 1;
            rv_wait = rvalid_delay;
            rv_addr = hs_addr;
            rdy_cnt = 0;
        end
        if (rv_pending) begin
            if (rv_wait == 0) begin
                i_mem_rvalid = 1;
                i_mem_rdata = mem.exists(rv_addr) ? mem[rv_addr] : 64'd0;
                rv_pending = 0;
            end else begin
                rv_wait--;
            end
        end
        i_mem_ready = 0;
        if (o_mem_req) begin
            if (rdy_cnt >= ready_delay) i_mem_ready = 1;
            else rdy_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, failures so far %0d", failures);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_mem_timing(input int rdy, input int rv);
        ready_delay = rdy;
        rvalid_delay = rv;
        rdy_cnt = 0;
    endtask

    function automatic logic [8:0] vpn_of(input logic [38:0] va, input int lvl);
        logic [38:0] t;
        t = va >> (12 + 9 * lvl);
        return t[8:0];
    endfunction

    function automatic logic [38:0] make_va(input logic [8:0] v2, input logic [8:0] v1,
                                            input logic [8:0] v0, input logic [11:0] off);
        return {v2, v1, v0, off};
    endfunction

    function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] flags);
        return {10'd0, ppn, 2'd0, flags};
    endfunction

    task automatic put_pte(input logic [43:0] table_ppn, input logic [38:0] va,
                           input int lvl, input logic [63:0] pte);
        mem[{table_ppn, vpn_of(va, lvl), 3'b000}] = pte;
    endtask

    // One miss from idle to its pulse; checks read count and optional latency.
    task automatic walk(input string name, input logic [38:0] va, input logic [43:0] satp,
                        input logic exp_fault, input logic [55:0] exp_pa,
                        input int exp_reads, input int exp_lat, output int base_h);
        int base_p;
        int t0;
        base_p = pulse_count;
        base_h = hs_count;
        exp_q.push_back('{exp_fault, exp_pa});
        step();
        i_tlb_miss = 1;
        i_tlb_miss_vaddr = va;
        i_satp_ppn = satp;
        t0 = cyc;
        step();
        i_tlb_miss = 0;
        for (int i = 0; i < 200; i++) begin
            if (pulse_count > base_p) break;
            step();
        end
        checks++;
        if (pulse_count <= base_p) begin
            failures++;
            $display("FAIL %s_timeout: no valid/fault pulse within 200 cycles", name);
        end else begin
            checks++;
            if (hs_count - base_h != exp_reads) begin
                failures++;
                $display("FAIL %s_reads: got %0d memory reads, required %0d", name, hs_count - base_h, exp_reads);
            end
            if (exp_lat > 0) begin
                checks++;
                if (pulse_cycs[$] - t0 != exp_lat) begin
                    failures++;
                    $display("FAIL %s_latency: got %0d cycles, required %0d", name, pulse_cycs[$] - t0, exp_lat);
                end
            end
        end
        step();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({o_ptw_valid, o_ptw_fault, o_mem_req} !== 3'b000 || o_ptw_paddr !== 56'd0 || o_mem_addr !== 56'd0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b fault=%b req=%b paddr=%h addr=%h, required all zero",
                     o_ptw_valid, o_ptw_fault, o_mem_req, o_ptw_paddr, o_mem_addr);
        end
        step();
        i_rstn = 1;
        step();
        step();
        @(negedge i_clk);
        checks++;
        if (o_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: got req=%b, required 0", o_mem_req);
        end
    endtask

    task automatic test_three_level();
        logic [38:0] va;
        logic [55:0] want [3];
        int base_h;
        va = make_va(9'h100, 9'h000, 9'h001, 12'hABC);
        put_pte(44'h100, va, 2, mk_pte(44'h200, NL));
        put_pte(44'h200, va, 1, mk_pte(44'h300, NL));
        put_pte(44'h300, va, 0, mk_pte(44'h12345, LEAF));
        want[0] = 56'h100800;
        want[1] = 56'h200000;
        want[2] = 56'h300008;
        set_mem_timing(0, 0);
        walk("three_level", va, 44'h100, 1'b0, 56'h12345000, 3, 7, base_h);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (hs_count <= base_h + i || hs_addrs[base_h + i] !== want[i]) begin
                failures++;
                $display("FAIL three_level_addr%0d: got %h, required %h", i,
                         (hs_count > base_h + i) ? hs_addrs[base_h + i] : 56'hx, want[i]);
            end
        end
    endtask

    task automatic test_gigapage();
        int base_h;
        put_pte(44'h100, 39'h12_3456_7000, 2, mk_pte(44'h80000, LEAF));
        set_mem_timing(0, 0);
        walk("gigapage", 39'h12_3456_7000, 44'h100, 1'b0, 56'hB456_7000, 1, 3, base_h);
        checks++;
        if (hs_count <= base_h || hs_addrs[base_h] !== 56'h100240) begin
            failures++;
            $display("FAIL gigapage_addr: got %h, required %h",
                     (hs_count > base_h) ? hs_addrs[base_h] : 56'hx, 56'h100240);
        end
    endtask

    task automatic test_faults();
        logic [38:0] va_m, va_v, va_w, va_n, va_a, va_l;
        int base_h;
        va_m = make_va(9'd1, 9'd2, 9'd3, 12'h0);
        va_v = make_va(9'd2, 9'd2, 9'd3, 12'h0);
        va_w = make_va(9'd3, 9'd0, 9'd0, 12'h0);
        va_n = make_va(9'd4, 9'd1, 9'd1, 12'h0);
        va_a = make_va(9'd5, 9'd7, 9'd9, 12'h0);
        va_l = make_va(9'd6, 9'd3, 9'h1AB, 12'h123);
        put_pte(44'h400, va_m, 2, mk_pte(44'h500, NL));
        put_pte(44'h500, va_m, 1, mk_pte(44'h12301, LEAF));
        put_pte(44'h400, va_v, 2, mk_pte(44'h501, NL));
        put_pte(44'h501, va_v, 1, mk_pte(44'h777, 8'h00));
        put_pte(44'h400, va_w, 2, mk_pte(44'h600, 8'h05));
        put_pte(44'h400, va_n, 2, mk_pte(44'h502, NL));
        put_pte(44'h502, va_n, 1, mk_pte(44'h503, NL));
        put_pte(44'h503, va_n, 0, mk_pte(44'h504, NL));
        put_pte(44'h400, va_a, 2, mk_pte(44'h40000, NOA));
        put_pte(44'h400, va_l, 2, mk_pte(44'h505, NL));
        put_pte(44'h505, va_l, 1, mk_pte(44'h12400, LEAF));
        set_mem_timing(0, 0);
        walk("misaligned_l1", va_m, 44'h400, 1'b1, 56'd0, 2, 0, base_h);
        walk("invalid_l1",    va_v, 44'h400, 1'b1, 56'd0, 2, 0, base_h);
        walk("write_only",    va_w, 44'h400, 1'b1, 56'd0, 1, 0, base_h);
        walk("pointer_l0",    va_n, 44'h400, 1'b1, 56'd0, 3, 0, base_h);
        walk("aligned_l1",    va_l, 44'h400, 1'b0, 56'h125AB000, 2, 0, base_h);
`ifdef CG_PTW_AD_CHECK_EN
        walk("a_clear", va_a, 44'h400, 1'b1, 56'd0, 1, 0, base_h);
`else
        walk("a_clear", va_a, 44'h400, 1'b0, 56'h40E09000, 1, 0, base_h);
`endif
    endtask

    task automatic test_stall();
        int base_h;
        int base_p;
        int bad_req;
        base_h = hs_count;
        base_p = pulse_count;
        bad_req = 0;
        set_mem_timing(5, 10);
        exp_q.push_back('{1'b0, 56'hB456_7000});
        step();
        i_tlb_miss = 1;
        i_tlb_miss_vaddr = 39'h12_3456_7000;
        i_satp_ppn = 44'h100;
        step();
        i_tlb_miss = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_mem_req !== 1'b1 || o_mem_addr !== 56'h100240) begin
                failures++;
                $display("FAIL stall_hold%0d: got req=%b addr=%h, required req=1 addr=%h",
                         i, o_mem_req, o_mem_addr, 56'h100240);
            end
        end
        for (int i = 0; i < 40; i++) begin
            if (pulse_count > base_p) break;
            step();
            @(negedge i_clk);
            if (o_mem_req !== 1'b0 && pulse_count == base_p) bad_req++;
        end
        checks++;
        if (pulse_count <= base_p || bad_req != 0 || hs_count - base_h != 1) begin
            failures++;
            $display("FAIL stall_single_req: pulses=%0d reqs=%0d req_while_wait=%0d, required 1/1/0",
                     pulse_count - base_p, hs_count - base_h, bad_req);
        end
        step();
        set_mem_timing(0, 0);
    endtask

    task automatic test_flush_wait();
        int base_h;
        int base_p;
        base_h = hs_count;
        base_p = pulse_count;
        set_mem_timing(0, 3);
        step();
        i_tlb_miss = 1;
        i_tlb_miss_vaddr = 39'h12_3456_7000;
        i_satp_ppn = 44'h100;
        step();
        i_tlb_miss = 0;
        step();
        i_flush = 1;
        step();
        i_flush = 0;
        repeat (8) step();
        @(negedge i_clk);
        checks++;
        if (pulse_count != base_p || hs_count - base_h != 1 || outstanding || o_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_wait: pulses=%0d reads=%0d outstanding=%0d req=%b, required 0/1/0/0",
                     pulse_count - base_p, hs_count - base_h, outstanding, o_mem_req);
        end
        set_mem_timing(0, 0);
        test_three_level();
    endtask

    task automatic test_flush_req();
        int base_h;
        int base_p;
        base_h = hs_count;
        base_p = pulse_count;
        set_mem_timing(3, 0);
        step();
        i_tlb_miss = 1;
        i_tlb_miss_vaddr = 39'h12_3456_7000;
        i_satp_ppn = 44'h100;
        step();
        i_tlb_miss = 0;
        step();
        i_flush = 1;
        step();
        i_flush = 0;
        repeat (6) step();
        checks++;
        if (pulse_count != base_p || hs_count != base_h) begin
            failures++;
            $display("FAIL flush_req: pulses=%0d reads=%0d, required 0/0",
                     pulse_count - base_p, hs_count - base_h);
        end
        set_mem_timing(0, 0);
    endtask

    task automatic test_back_to_back();
        int base_h;
        int base_p;
        int t0;
        base_h = hs_count;
        base_p = pulse_count;
        set_mem_timing(0, 0);
        exp_q.push_back('{1'b0, 56'hB456_7000});
        exp_q.push_back('{1'b0, 56'hB456_7000});
        step();
        i_tlb_miss = 1;
        i_tlb_miss_vaddr = 39'h12_3456_7000;
        i_satp_ppn = 44'h100;
        t0 = cyc;
        for (int i = 0; i < 30; i++) begin
            step();
            if (pulse_count >= base_p + 2) break;
        end
        i_tlb_miss = 0;
        checks++;
        if (pulse_count != base_p + 2 || hs_count - base_h != 2) begin
            failures++;
            $display("FAIL b2b_count: pulses=%0d reads=%0d, required 2/2",
                     pulse_count - base_p, hs_count - base_h);
        end else begin
            checks++;
            if (pulse_cycs[$-1] - t0 != 3 || pulse_cycs[$] - pulse_cycs[$-1] != 4) begin
                failures++;
                $display("FAIL b2b_timing: first=%0d gap=%0d, required 3/4",
                         pulse_cycs[$-1] - t0, pulse_cycs[$] - pulse_cycs[$-1]);
            end
        end
        step();
    endtask

    task automatic test_reset_mid_walk();
        logic [38:0] va;
        int base_h;
        va = make_va(9'h100, 9'h000, 9'h001, 12'hABC);
        set_mem_timing(0, 0);
        exp_q.push_back('{1'b0, 56'h12345000});
        step();
        i_tlb_miss = 1;
        i_tlb_miss_vaddr = va;
        i_satp_ppn = 44'h100;
        step();
        i_tlb_miss = 0;
        step();
        step();
        @(posedge i_clk);
        #3;
        i_rstn = 0;
        #1;
        checks++;
        if ({o_ptw_valid, o_ptw_fault, o_mem_req} !== 3'b000 || o_ptw_paddr !== 56'd0 || o_mem_addr !== 56'd0) begin
            failures++;
            $display("FAIL reset_mid_walk: valid=%b fault=%b req=%b paddr=%h addr=%h, required all zero",
                     o_ptw_valid, o_ptw_fault, o_mem_req, o_ptw_paddr, o_mem_addr);
        end
        exp_q.delete();
        outstanding = 0;
        rv_pending = 0;
        hs_seen = 0;
        rdy_cnt = 0;
        step();
        step();
        i_rstn = 1;
        step();
        walk("after_reset", va, 44'h100, 1'b0, 56'h12345000, 3, 7, base_h);
    endtask

    initial begin
        test_reset();
        test_three_level();
        test_gigapage();
        test_faults();
        test_stall();
        test_flush_wait();
        test_flush_req();
        test_back_to_back();
        test_reset_mid_walk();
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d results still expected, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
